avalon_req_arbiter: RTL
=======================

AVALON_REQ_ARBITER -- requirements
Module: avalon_req_arbiter

Interface
REQ-001 One clock; reset is synchronous and active-high. The clock port is clk and the reset port is n_rst; n_rst=1 sampled at a rising clk edge resets the block.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock
- n_rst  in  1  synchronous active-high reset
- rd_req  in  1  read requester (pixel fetch) request level
- rd_addr  in  32  read SRAM address, stable while rd_req=1
- rd_ack  out  1  one-cycle read completion pulse
- rd_data  out  32  read data, valid while rd_ack=1
- rd_err  out  1  read timeout flag, valid while rd_ack=1
- wr_req  in  1  write requester (result store) request level
- wr_addr  in  32  write SRAM address, stable while wr_req=1
- wr_data  in  32  write data, stable while wr_req=1
- wr_ack  out  1  one-cycle write completion pulse
- m_readen  out  1  read start to the Avalon master FSM
- m_writen  out  1  write start to the Avalon master FSM
- m_inaddr  out  32  address to the master FSM
- m_wdata  out  32  write data to the master FSM
- m_dataready  in  1  master FSM read-data-valid strobe
- m_readdata  in  32  Avalon readdata bus
- busy  out  1  high in every state except IDLE

Function
REQ-003 States SHALL be IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, ACK.
REQ-004 Requester handshake: req is held high with addr/data stable until ack; the requester deasserts req in the cycle after ack.
REQ-005 In IDLE with the quiet counter expired, if exactly one req=1, that requester SHALL be granted; if both, the one not served last SHALL be granted (last_grant register, round-robin).
REQ-006 On grant, the address (plus wr_data for writes) SHALL be registered into m_inaddr/m_wdata and held constant until ACK is left.
REQ-007 RD_ISSUE: m_readen=1 for exactly one cycle; next state RD_WAIT.
REQ-008 RD_WAIT: on m_dataready=1, capture m_readdata into rd_data and set rd_err=0, then go to ACK; nominal dwell is 3 cycles.
REQ-009 RD_WAIT timeout: if 8 cycles elapse without m_dataready, go to ACK with rd_data=0 and rd_err=1.
REQ-010 WR_ISSUE: m_writen=1 for exactly one cycle; next state WR_WAIT. WR_WAIT lasts exactly 2 cycles (counter), then ACK.
REQ-011 ACK lasts one cycle: rd_ack=1 or wr_ack=1 according to the grant; last_grant updated; next state IDLE.
REQ-012 Latency: with req sampled high in IDLE at cycle i, a read acks at i+5 and a write acks at i+4; back-to-back grants are separated by at least one IDLE cycle.
REQ-013 m_readen and m_writen SHALL never be high in the same cycle; both SHALL be 0 outside the ISSUE states.
REQ-014 m_dataready seen outside RD_WAIT SHALL be ignored.
REQ-015 A req dropped before its ack is a protocol violation; the transaction SHALL still complete and ack normally.

Reset
REQ-016 On reset: state=IDLE, last_grant=WRITE (so read wins the first contention); every output = 0 (rd_ack, rd_data, rd_err, wr_ack, m_readen, m_writen, m_inaddr, m_wdata, busy).
REQ-017 Reset mid-transaction SHALL abort it with no ack issued. After reset the block SHALL hold IDLE for 4 quiet cycles before its first grant, letting the master FSM drain.

Structure
REQ-018 Package sobel_mem_pkg SHALL hold the state enum, grant enum {READ, WRITE}, ADDR_W=32, DATA_W=32, WR_WAIT_CYCLES=2, RD_TIMEOUT=8, RST_QUIET=4.
REQ-019 Single module, no sub-module: the 2-way round-robin pick is inline.

Verification
REQ-020 Bench SHALL include a behavioural master-FSM model (dataready 3 cycles after readen) and cover:
- Read: rd_req with rd_addr=0x100 and model readdata 0xDEADBEEF -> m_readen one pulse; rd_ack at i+5 with rd_data=0xDEADBEEF and rd_err=0.
- Write: wr_req with wr_addr=0x200 and wr_data=0x55 -> m_writen one pulse; m_inaddr=0x200 held for 3 cycles; wr_ack at i+4.
- Contention: both reqs held continuously after reset -> grants alternate RD, WR, RD, WR; first grant is read.
- Timeout: model never raises dataready -> rd_ack 9 cycles after RD_ISSUE with rd_err=1 and rd_data=0.
- Reset in RD_WAIT -> no ack, all outputs 0; rd_req held -> no m_readen until the 5th cycle after reset deasserts.
- Stray m_dataready in IDLE -> no ack and rd_data unchanged.

Source files
------------

// File: rtl/sobel_mem_pkg.sv
// Shared types and constants for the SRAM request arbiter in front of the Avalon master FSM.
package sobel_mem_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned WR_WAIT_CYCLES = 2;
  localparam int unsigned RD_TIMEOUT     = 8;
  localparam int unsigned RST_QUIET      = 4;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT,
    ACK
  } state_e;

  typedef enum logic {
    READ,
    WRITE
  } grant_e;

  // Command presented to the Avalon master FSM for the granted transaction
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_cmd_t;

endpackage

// File: rtl/avalon_req_arbiter_if.sv
// Requester and master-FSM signal bundle; slave is the arbiter's view, master the environment's.
interface avalon_req_arbiter_if;

  logic                              rd_req;
  logic [sobel_mem_pkg::ADDR_W-1:0]  rd_addr;
  logic                              rd_ack;
  logic [sobel_mem_pkg::DATA_W-1:0]  rd_data;
  logic                              rd_err;
  logic                              wr_req;
  logic [sobel_mem_pkg::ADDR_W-1:0]  wr_addr;
  logic [sobel_mem_pkg::DATA_W-1:0]  wr_data;
  logic                              wr_ack;
  logic                              m_readen;
  logic                              m_writen;
  logic [sobel_mem_pkg::ADDR_W-1:0]  m_inaddr;
  logic [sobel_mem_pkg::DATA_W-1:0]  m_wdata;
  logic                              m_dataready;
  logic [sobel_mem_pkg::DATA_W-1:0]  m_readdata;
  logic                              busy;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, m_dataready, m_readdata,
    output rd_ack, rd_data, rd_err, wr_ack, m_readen, m_writen, m_inaddr, m_wdata, busy
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, m_dataready, m_readdata,
    input  rd_ack, rd_data, rd_err, wr_ack, m_readen, m_writen, m_inaddr, m_wdata, busy
  );

endinterface

// File: rtl/avalon_req_arbiter.sv
// Two-requester round-robin arbiter (pixel fetch read / result store write) driving one
// Avalon master FSM; one transaction in flight, read timeout, post-reset quiet window.
module avalon_req_arbiter
  import sobel_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  avalon_req_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  quiet_q, quiet_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_err_q, rd_err_d;
  logic              rd_ack_q, rd_ack_d;
  logic              wr_ack_q, wr_ack_d;
  logic              readen_q, readen_d;
  logic              writen_q, writen_d;
  logic              busy_q, busy_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q      <= IDLE;
      grant_q      <= READ;
      last_grant_q <= WRITE;
      cnt_q        <= '0;
      quiet_q      <= CNT_W'(RST_QUIET);
      cmd_q        <= '0;
      rd_data_q    <= '0;
      rd_err_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      readen_q     <= 1'b0;
      writen_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      quiet_q      <= quiet_d;
      cmd_q        <= cmd_d;
      rd_data_q    <= rd_data_d;
      rd_err_q     <= rd_err_d;
      rd_ack_q     <= rd_ack_d;
      wr_ack_q     <= wr_ack_d;
      readen_q     <= readen_d;
      writen_q     <= writen_d;
      busy_q       <= busy_d;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    quiet_d      = quiet_q;
    cmd_d        = cmd_q;
    rd_data_d    = rd_data_q;
    rd_err_d     = rd_err_q;

    case (state_q)
      IDLE: begin
        if (quiet_q != '0) begin
          quiet_d = quiet_q - CNT_W'(1);
        end else if (bus.rd_req && (!bus.wr_req || last_grant_q == WRITE)) begin
          grant_d    = READ;
          cmd_d.addr = bus.rd_addr;
          state_d    = RD_ISSUE;
        end else if (bus.wr_req) begin
          grant_d    = WRITE;
          cmd_d.addr = bus.wr_addr;
          cmd_d.data = bus.wr_data;
          state_d    = WR_ISSUE;
        end
      end

      RD_ISSUE: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (bus.m_dataready) begin
          rd_data_d = bus.m_readdata;
          rd_err_d  = 1'b0;
          state_d   = ACK;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          rd_data_d = '0;
          rd_err_d  = 1'b1;
          state_d   = ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR_ISSUE: begin
        cnt_d   = '0;
        state_d = WR_WAIT;
      end

      WR_WAIT: begin
        if (cnt_q == CNT_W'(WR_WAIT_CYCLES - 1)) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ACK: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    readen_d = (state_d == RD_ISSUE);
    writen_d = (state_d == WR_ISSUE);
    rd_ack_d = (state_d == ACK) && (grant_d == READ);
    wr_ack_d = (state_d == ACK) && (grant_d == WRITE);
    busy_d   = (state_d != IDLE);
  end

  assign bus.rd_ack   = rd_ack_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.m_readen = readen_q;
  assign bus.m_writen = writen_q;
  assign bus.m_inaddr = cmd_q.addr;
  assign bus.m_wdata  = cmd_q.data;
  assign bus.busy     = busy_q;

endmodule
